row_load_sequencer: RTL and testbench
=====================================

# row_load_sequencer

Controller for the four-slot row buffer (`row_arbiter`) in the ESPNet convolution datapath. Accepts a stream of rows from the feature-map fetch unit and issues the 3-bit `control` code that steers each row into a free slot, rotating through the four slots as a ring. Presents a 3-row sliding window to the convolution engine, with the slot index of each row, and frees the oldest slot when the engine finishes a window. Sits between the fetch unit, `row_arbiter` and the 3x3 convolution engine.

## Interface
- `ROW_CNT_W`, 10: width of the row counters and of `num_rows`.
- `clock` input 1: single clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `start` input 1: one-cycle pulse that begins a feature map; sampled only in IDLE.
- `num_rows` input ROW_CNT_W: total rows in the map; latched on `start`.
- `row_valid` input 1: fetch unit presents a row on the `row_arbiter` data input.
- `row_ready` output 1: sequencer can accept a row this cycle.
- `control` output 3: drives `row_arbiter.control`; 3'd1..3'd4 load slot 0..3; 3'd0 holds.
- `win_valid` output 1: a 3-row window is resident and offered to the engine.
- `win_ready` input 1: engine has finished the offered window.
- `win_slot0/1/2` output 2 each: slot index of the top, middle and bottom window row.
- `busy` output 1: high from the cycle after an accepted `start` until DONE.
- `done` output 1: one-cycle pulse when the map completes.
- `err` output 1: sticky; set when `start` carries `num_rows < 3`; cleared by the next accepted `start` or by reset.

## Operation
- States: IDLE, FILL, RUN, DONE.
  - IDLE: on `start`, latch `num_rows` and go to FILL. If `num_rows < 3`, set `err` and go to DONE.
  - FILL: go to RUN once occupancy reaches 3.
  - RUN: go to DONE when the last window is accepted.
  - DONE: lasts one cycle, then IDLE.
- Registers:
  - `wr_ptr`, `rd_ptr`: 2-bit, mod-4 wrap.
  - `occ`: 0..4.
  - `rows_loaded`, `wins_issued`: ROW_CNT_W bits.
- Total windows = `num_rows - 2`.
- `row_ready` = (FILL or RUN) and `occ < 4` and `rows_loaded < num_rows`.
- Row accept (`row_valid && row_ready`):
  - `control` = `wr_ptr + 1` in that same cycle, combinational from registered `wr_ptr` and the accept. Otherwise `control` = 3'd0.
  - Next cycle: `wr_ptr`+1, `occ`+1, `rows_loaded`+1.
- `win_valid` = RUN and `occ >= 3` and `wins_issued < num_rows - 2`.
- `win_slot0` = `rd_ptr`, `win_slot1` = `rd_ptr+1`, `win_slot2` = `rd_ptr+2` (mod 4). These hold stable while `win_valid` is high.
- Window accept (`win_valid && win_ready`): next cycle `rd_ptr`+1, `occ`-1, `wins_issued`+1.
- Row accept and window accept in the same cycle: `occ` unchanged, both pointers advance.
- After all rows are loaded, `row_ready` stays low. RUN continues until `wins_issued` reaches `num_rows - 2`. Up to 2 rows remain resident at the end; they are discarded, not freed individually.
- `start` outside IDLE is ignored.
- Reset mid-operation: every register returns to its reset value immediately and the state goes to IDLE. Recovery needs a new `start`.

## Timing
- Reset values:
  - All outputs 0 (`control` 3'd0, `win_slot*` 2'd0).
  - `wr_ptr`, `rd_ptr`, `occ` and all counters 0; state IDLE.
- `start` in cycle t: `busy` and `row_ready` go high at t+1.
- Third row accepted in cycle t: `win_valid` goes high at t+1.
- Window accepted in cycle t: the freed slot is accepting again at t+1 (`row_ready` back high if it was low because `occ` was 4).
- Last window accepted in cycle t: DONE, `done`=1 and `busy`=0 at t+1; IDLE at t+2.
- Streaming throughput: one row and one window per cycle.

## Structure
- Shared package `espnet_row_pkg`:
  - state enum (IDLE, FILL, RUN, DONE);
  - `NUM_SLOTS`=4, `KERNEL_ROWS`=3;
  - control codes `CTRL_HOLD`=3'd0 and `CTRL_SLOT0..3`=3'd1..3'd4. `row_arbiter` decodes against the same codes.
- No sub-module. FSM, pointers and counters sit in one module.

## Test plan
- `num_rows`=5, `row_valid` and `win_ready` held high:
  - `control` sequence is 1,2,3,4,1;
  - windows report (`win_slot0,1,2`) = (0,1,2), (1,2,3), (2,3,0);
  - `done` pulses once; exactly 3 window accepts.
- `num_rows`=8, `win_ready` low:
  - after 4 row accepts, `row_ready`=0 and `occ`=4;
  - one `win_ready` pulse re-enables `row_ready` the next cycle, and the next row loads with `control`=1.
- Row accept and window accept in the same cycle: `occ` unchanged, both pointers advance, `win_slot*` updates next cycle.
- `start` with `num_rows`=2:
  - `err`=1, `done` pulse, no nonzero `control`;
  - a following `start` with `num_rows`=3 clears `err` and yields 1 window.
- Async reset asserted mid-RUN (`occ`=3):
  - all outputs 0 immediately, including `control`, even with `row_valid` high;
  - after release, `start` with 4 rows produces `control` 1,2,3,4.
- `start` pulsed during RUN: ignored; `num_rows` latch and counters unchanged.

Source files
------------

// File: rtl/row_load_sequencer_pkg.sv
// Shared definitions for the ESPNet row buffer path: FSM state encoding,
// buffer geometry and the row_arbiter control codes (row_arbiter decodes
// against the same constants).
package espnet_row_pkg;

  localparam int ROW_CNT_W   = 10;
  localparam int NUM_SLOTS   = 4;
  localparam int KERNEL_ROWS = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [2:0] CTRL_HOLD  = 3'd0;
  localparam logic [2:0] CTRL_SLOT0 = 3'd1;
  localparam logic [2:0] CTRL_SLOT1 = 3'd2;
  localparam logic [2:0] CTRL_SLOT2 = 3'd3;
  localparam logic [2:0] CTRL_SLOT3 = 3'd4;

  // Load code that steers a row into the given slot.
  function automatic logic [2:0] slot_ctrl(input logic [1:0] slot);
    case (slot)
      2'd0:    slot_ctrl = CTRL_SLOT0;
      2'd1:    slot_ctrl = CTRL_SLOT1;
      2'd2:    slot_ctrl = CTRL_SLOT2;
      2'd3:    slot_ctrl = CTRL_SLOT3;
      default: slot_ctrl = CTRL_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/row_load_sequencer_if.sv
// Handshake bundle between the sequencer and its neighbours.
//   master: fetch unit / conv engine side (drives start, num_rows,
//           row_valid, win_ready)
//   slave : row_load_sequencer (drives row_ready, control, window and
//           status outputs)
interface row_load_sequencer_if;
  import espnet_row_pkg::*;

  logic                 start;
  logic [ROW_CNT_W-1:0] num_rows;
  logic                 row_valid;
  logic                 row_ready;
  logic [2:0]           control;
  logic                 win_valid;
  logic                 win_ready;
  logic [1:0]           win_slot0;
  logic [1:0]           win_slot1;
  logic [1:0]           win_slot2;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, num_rows, row_valid, win_ready,
    input  row_ready, control, win_valid, win_slot0, win_slot1, win_slot2,
           busy, done, err
  );

  modport slave (
    input  start, num_rows, row_valid, win_ready,
    output row_ready, control, win_valid, win_slot0, win_slot1, win_slot2,
           busy, done, err
  );

endinterface

// File: rtl/row_load_sequencer.sv
// Row load sequencer for the four-slot row_arbiter buffer. Loads incoming
// rows into slots as a ring, offers 3-row windows to the conv engine and
// frees the oldest slot per consumed window.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous, active-low
//   bus   - row_load_sequencer_if.slave (start/num_rows, row handshake +
//           control code, window handshake + slot indices, busy/done/err)
//
// state | meaning
// IDLE  | waiting for start
// FILL  | loading rows until three are resident
// RUN   | offering windows while loading remaining rows
// DONE  | one-cycle completion (done pulse), then IDLE
module row_load_sequencer
  import espnet_row_pkg::*;
(
  input logic                 clock,
  input logic                 reset,
  row_load_sequencer_if.slave bus
);

  state_t               r_state;
  logic [1:0]           r_wr_ptr;
  logic [1:0]           r_rd_ptr;
  logic [2:0]           r_occ;
  logic [ROW_CNT_W-1:0] r_num_rows;
  logic [ROW_CNT_W-1:0] r_rows_loaded;
  logic [ROW_CNT_W-1:0] r_wins_issued;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic                 w_active;
  logic                 w_row_ready;
  logic                 w_win_valid;
  logic                 w_row_acc;
  logic                 w_win_acc;
  logic                 w_last_win;
  logic [ROW_CNT_W-1:0] w_total_wins;
  logic [2:0]           w_occ_next;

  assign w_active     = (r_state == ST_FILL) || (r_state == ST_RUN);
  assign w_total_wins = r_num_rows - ROW_CNT_W'(KERNEL_ROWS - 1);
  assign w_row_ready  = w_active && (r_occ < 3'(NUM_SLOTS)) &&
                        (r_rows_loaded < r_num_rows);
  assign w_win_valid  = (r_state == ST_RUN) && (r_occ >= 3'(KERNEL_ROWS)) &&
                        (r_wins_issued < w_total_wins);
  assign w_row_acc    = bus.row_valid && w_row_ready;
  assign w_win_acc    = w_win_valid && bus.win_ready;
  assign w_last_win   = (r_wins_issued + ROW_CNT_W'(1)) == w_total_wins;

  always_comb begin
    w_occ_next = r_occ;
    case ({w_row_acc, w_win_acc})
      2'b10:   w_occ_next = r_occ + 3'd1;
      2'b01:   w_occ_next = r_occ - 3'd1;
      default: w_occ_next = r_occ;
    endcase
  end

  // Control is combinational so the arbiter captures the row in the same
  // cycle the fetch unit presents it.
  assign bus.control   = w_row_acc ? slot_ctrl(r_wr_ptr) : CTRL_HOLD;
  assign bus.row_ready = w_row_ready;
  assign bus.win_valid = w_win_valid;
  // Slot indices are forced to zero outside a valid window so every output
  // reads zero out of reset.
  assign bus.win_slot0 = w_win_valid ? r_rd_ptr          : 2'd0;
  assign bus.win_slot1 = w_win_valid ? r_rd_ptr + 2'd1   : 2'd0;
  assign bus.win_slot2 = w_win_valid ? r_rd_ptr + 2'd2   : 2'd0;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= 2'd0;
      r_rd_ptr      <= 2'd0;
      r_occ         <= 3'd0;
      r_num_rows    <= '0;
      r_rows_loaded <= '0;
      r_wins_issued <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            // Rows left over from a previous map are simply abandoned.
            r_num_rows    <= bus.num_rows;
            r_wr_ptr      <= 2'd0;
            r_rd_ptr      <= 2'd0;
            r_occ         <= 3'd0;
            r_rows_loaded <= '0;
            r_wins_issued <= '0;
            if (bus.num_rows < ROW_CNT_W'(KERNEL_ROWS)) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_err   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= ST_FILL;
            end
          end
        end
        ST_FILL, ST_RUN: begin
          if (w_row_acc) begin
            r_wr_ptr      <= r_wr_ptr + 2'd1;
            r_rows_loaded <= r_rows_loaded + ROW_CNT_W'(1);
          end
          if (w_win_acc) begin
            r_rd_ptr      <= r_rd_ptr + 2'd1;
            r_wins_issued <= r_wins_issued + ROW_CNT_W'(1);
          end
          r_occ <= w_occ_next;
          if ((r_state == ST_FILL) && (w_occ_next >= 3'(KERNEL_ROWS)))
            r_state <= ST_RUN;
          if (w_win_acc && w_last_win) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_load_sequencer.sv
// Bench for row_load_sequencer: table of whole-map runs checked against a
// scoreboard of expected control codes and window slot triples, plus
// hand-written sequences for back-pressure, simultaneous accepts and reset.
module tb_row_load_sequencer;
  import espnet_row_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  row_load_sequencer_if bus ();

  row_load_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int n;
    int exp_wins;
    bit exp_err;
    bit restart;
  } vec_t;

  vec_t vecs [6];

  int n_checks = 0;
  int n_fail   = 0;
  int win_cnt  = 0;
  int done_cnt = 0;
  bit sb_en    = 1'b0;

  logic [2:0] exp_ctrl [$];
  logic [5:0] exp_win  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_expect(input int rows, input int wins);
    for (int i = 0; i < rows; i++) exp_ctrl.push_back(3'((i % 4) + 1));
    for (int k = 0; k < wins; k++)
      exp_win.push_back({2'(k % 4), 2'((k + 1) % 4), 2'((k + 2) % 4)});
  endtask

  // Scoreboard: every nonzero control code and every window accept is
  // matched against the front of the expected queues.
  always @(negedge clock) begin
    if (sb_en) begin
      if (bus.control != 3'd0) begin
        if (exp_ctrl.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ctrl_extra: got %0d expected none", bus.control);
        end else begin
          check("ctrl_seq", 32'(bus.control), 32'(exp_ctrl.pop_front()));
        end
      end
      if (bus.win_valid && bus.win_ready) begin
        win_cnt++;
        if (exp_win.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL win_extra: got slots %0d,%0d,%0d expected none",
                   bus.win_slot0, bus.win_slot1, bus.win_slot2);
        end else begin
          check("win_slots", 32'({bus.win_slot0, bus.win_slot1, bus.win_slot2}),
                32'(exp_win.pop_front()));
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic start_map(input int n, input logic wr, input bit exp_err);
    step();
    bus.start     = 1'b1;
    bus.num_rows  = ROW_CNT_W'(n);
    bus.row_valid = 1'b1;
    bus.win_ready = wr;
    step();
    bus.start = 1'b0;
    @(negedge clock);
    check("start_busy",      32'(bus.busy),      32'(!exp_err));
    check("start_row_ready", 32'(bus.row_ready), 32'(!exp_err));
    check("start_err",       32'(bus.err),       32'(exp_err));
  endtask

  task automatic finish_map(input int n, input int exp_wins, input bit exp_err, input bit restart);
    int cyc = 0;
    while (!bus.done && cyc < 400) begin
      if (restart && cyc == 3) begin
        bus.start    = 1'b1;
        bus.num_rows = ROW_CNT_W'(3);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    bus.start = 1'b0;
    check("done_seen",  32'(bus.done), 32'd1);
    check("done_busy",  32'(bus.busy), 32'd0);
    check("done_err",   32'(bus.err),  32'(exp_err));
    @(negedge clock);
    check("done_single",  32'(bus.done),        32'd0);
    check("done_count",   32'(done_cnt),        32'd1);
    check("win_count",    32'(win_cnt),         32'(exp_wins));
    check("ctrl_q_empty", 32'(exp_ctrl.size()), 32'd0);
    check("win_q_empty",  32'(exp_win.size()),  32'd0);
    if (restart) check("restart_ignored", 32'(dut.r_num_rows), 32'(n));
    bus.row_valid = 1'b0;
    bus.win_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    win_cnt  = 0;
    done_cnt = 0;
    push_expect(v.exp_err ? 0 : v.n, v.exp_wins);
    start_map(v.n, 1'b1, v.exp_err);
    finish_map(v.n, v.exp_wins, v.exp_err, v.restart);
  endtask

  initial begin
    vecs[0] = '{n: 5, exp_wins: 3, exp_err: 1'b0, restart: 1'b0};
    vecs[1] = '{n: 3, exp_wins: 1, exp_err: 1'b0, restart: 1'b0};
    vecs[2] = '{n: 2, exp_wins: 0, exp_err: 1'b1, restart: 1'b0};
    vecs[3] = '{n: 3, exp_wins: 1, exp_err: 1'b0, restart: 1'b0};
    vecs[4] = '{n: 7, exp_wins: 5, exp_err: 1'b0, restart: 1'b0};
    vecs[5] = '{n: 6, exp_wins: 4, exp_err: 1'b0, restart: 1'b1};

    bus.start     = 1'b0;
    bus.num_rows  = '0;
    bus.row_valid = 1'b1;
    bus.win_ready = 1'b0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_control",   32'(bus.control),   32'd0);
    check("rst_row_ready", 32'(bus.row_ready), 32'd0);
    check("rst_win_valid", 32'(bus.win_valid), 32'd0);
    check("rst_slots",     32'({bus.win_slot0, bus.win_slot1, bus.win_slot2}), 32'd0);
    check("rst_status",    32'({bus.busy, bus.done, bus.err}), 32'd0);
    reset = 1'b1;
    bus.row_valid = 1'b0;
    sb_en = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Back-pressure: fill all four slots, then free one and load into it
    // while a second window is consumed in the same cycle.
    win_cnt  = 0;
    done_cnt = 0;
    push_expect(8, 6);
    start_map(8, 1'b0, 1'b0);
    begin
      int cyc = 0;
      while (bus.row_ready && cyc < 50) begin
        @(negedge clock);
        cyc++;
      end
    end
    check("full_row_ready", 32'(bus.row_ready),   32'd0);
    check("full_occ",       32'(dut.r_occ),       32'd4);
    check("full_ctrl_left", 32'(exp_ctrl.size()), 32'd4);
    check("full_win_valid", 32'(bus.win_valid),   32'd1);
    step();
    bus.win_ready = 1'b1;
    @(negedge clock);
    check("pulse_row_ready", 32'(bus.row_ready), 32'd0);
    step();
    @(negedge clock);
    check("free_row_ready", 32'(bus.row_ready), 32'd1);
    check("free_control",   32'(bus.control),   32'd1);
    check("free_slot0",     32'(bus.win_slot0), 32'd1);
    step();
    @(negedge clock);
    check("both_occ",     32'(dut.r_occ),     32'd3);
    check("both_slot0",   32'(bus.win_slot0), 32'd2);
    check("both_slot2",   32'(bus.win_slot2), 32'd0);
    check("both_control", 32'(bus.control),   32'd2);
    finish_map(8, 6, 1'b0, 1'b0);

    // Asynchronous reset in RUN with three rows resident
    win_cnt  = 0;
    done_cnt = 0;
    push_expect(5, 3);
    start_map(5, 1'b0, 1'b0);
    begin
      int cyc = 0;
      while (!bus.win_valid && cyc < 20) begin
        @(negedge clock);
        cyc++;
      end
    end
    check("prerst_occ", 32'(dut.r_occ), 32'd3);
    #2;
    sb_en = 1'b0;
    reset = 1'b0;
    #1;
    check("arst_control",   32'(bus.control),   32'd0);
    check("arst_row_ready", 32'(bus.row_ready), 32'd0);
    check("arst_win_valid", 32'(bus.win_valid), 32'd0);
    check("arst_slots",     32'({bus.win_slot0, bus.win_slot1, bus.win_slot2}), 32'd0);
    check("arst_status",    32'({bus.busy, bus.done, bus.err}), 32'd0);
    exp_ctrl.delete();
    exp_win.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    bus.row_valid = 1'b0;
    sb_en = 1'b1;
    run_vec('{n: 4, exp_wins: 2, exp_err: 1'b0, restart: 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
